// File: rtl/vlc_word_packer.sv
// Packs glued VLC words through a 2**AW-deep first-word-fall-through FIFO onto a
// valid/ready stream, and closes each run with a {TRAILER_TAG, word count} trailer.
module vlc_word_packer #(
    parameter int unsigned AW          = 4,
    parameter logic [15:0] TRAILER_TAG = 16'hEC0D
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          encode_start,
    input  logic          encode_done,
    input  logic [31:0]   vlc_glue_data,
    input  logic          vlc_glue_valid,
    output logic [31:0]   out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW:0]   fifo_level,
    output logic          overflow,
    output logic [15:0]   word_cnt,
    output logic          pack_done
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned DW    = 32;
    localparam int unsigned CW    = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_TRAILER,
        S_DONE
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] wr_ptr, wr_ptr_n;
    logic [PW-1:0] rd_ptr, rd_ptr_n;
    logic [CW-1:0] word_cnt_n;
    logic          overflow_n;
    logic          done_seen, done_seen_n;
    logic          out_valid_n;
    logic [DW-1:0] out_data_n;
    logic [PW-1:0] fifo_level_n;
    logic          pack_done_n;

    logic [DW-1:0] mem [DEPTH];

    logic full_c;
    logic empty_c;
    logic push_c;
    logic pop_c;

    assign empty_c = (wr_ptr == rd_ptr);
    assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_c  = (state == S_RUN) && vlc_glue_valid && !full_c;
    assign pop_c   = (state == S_RUN) && !empty_c && out_ready;

    // FIFO storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr[AW-1:0]] <= vlc_glue_data;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            word_cnt   <= '0;
            overflow   <= 1'b0;
            done_seen  <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            fifo_level <= '0;
            pack_done  <= 1'b0;
        end else begin
            state      <= state_n;
            wr_ptr     <= wr_ptr_n;
            rd_ptr     <= rd_ptr_n;
            word_cnt   <= word_cnt_n;
            overflow   <= overflow_n;
            done_seen  <= done_seen_n;
            out_valid  <= out_valid_n;
            out_data   <= out_data_n;
            fifo_level <= fifo_level_n;
            pack_done  <= pack_done_n;
        end
    end

    always_comb begin
        state_n      = state;
        wr_ptr_n     = wr_ptr;
        rd_ptr_n     = rd_ptr;
        word_cnt_n   = word_cnt;
        overflow_n   = overflow;
        done_seen_n  = done_seen;
        out_valid_n  = 1'b0;
        out_data_n   = '0;
        fifo_level_n = '0;
        pack_done_n  = 1'b0;

        unique case (state)
            S_IDLE, S_DONE: begin
                if (encode_start) begin
                    state_n     = S_RUN;
                    wr_ptr_n    = '0;
                    rd_ptr_n    = '0;
                    word_cnt_n  = '0;
                    overflow_n  = 1'b0;
                    done_seen_n = 1'b0;
                end
            end
            S_RUN: begin
                if (push_c) begin
                    wr_ptr_n = wr_ptr + PW'(1);
                end
                if (vlc_glue_valid && full_c) begin
                    overflow_n = 1'b1;
                end
                if (pop_c) begin
                    rd_ptr_n   = rd_ptr + PW'(1);
                    word_cnt_n = word_cnt + CW'(1);
                end
                if (encode_done) begin
                    done_seen_n = 1'b1;
                end
                if (done_seen && empty_c && !vlc_glue_valid) begin
                    state_n = S_TRAILER;
                end
            end
            S_TRAILER: begin
                if (out_ready) begin
                    state_n = S_DONE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Registered outputs are built from next-state values; a word landing in the
        // head slot this edge is forwarded straight from the input bus.
        fifo_level_n = wr_ptr_n - rd_ptr_n;
        pack_done_n  = (state_n == S_DONE);
        if (state_n == S_TRAILER) begin
            out_valid_n = 1'b1;
            out_data_n  = {TRAILER_TAG, word_cnt_n};
        end else if ((state_n == S_RUN) && (wr_ptr_n != rd_ptr_n)) begin
            out_valid_n = 1'b1;
            out_data_n  = (push_c && (rd_ptr_n == wr_ptr)) ? vlc_glue_data
                                                            : mem[rd_ptr_n[AW-1:0]];
        end
    end

endmodule

// File: tb/tb_vlc_word_packer.sv
// Self-checking bench for vlc_word_packer: table-driven runs plus hand-written
// overflow, full-collision, trailer-hold and mid-run reset sequences.
module tb_vlc_word_packer;

    localparam logic [15:0] TAG = 16'hEC0D;

    logic        clk = 1'b0;
    logic        rstN;
    logic        encode_start;
    logic        encode_done;
    logic [31:0] vlc_glue_data;
    logic        vlc_glue_valid;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic [15:0] word_cnt;
    logic        pack_done;

    int errors = 0;
    int checks = 0;
    logic [31:0] sb[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;

    vlc_word_packer dut (
        .clk            (clk),
        .rstN           (rstN),
        .encode_start   (encode_start),
        .encode_done    (encode_done),
        .vlc_glue_data  (vlc_glue_data),
        .vlc_glue_valid (vlc_glue_valid),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .fifo_level     (fifo_level),
        .overflow       (overflow),
        .word_cnt       (word_cnt),
        .pack_done      (pack_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Scoreboard and hold checker, sampled mid-cycle while inputs are stable
    always @(negedge clk) begin
        if (!rstN) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %h expected none", out_data);
                end else begin
                    check("out_word", out_data, sb.pop_front());
                end
            end
            prev_stall <= out_valid && !out_ready;
            prev_data  <= out_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        encode_start = 1'b1;
        step();
        encode_start = 1'b0;
    endtask

    task automatic write_word(input logic [31:0] d, input logic rdy);
        vlc_glue_valid = 1'b1;
        vlc_glue_data  = d;
        out_ready      = rdy;
        step();
        vlc_glue_valid = 1'b0;
    endtask

    task automatic finish_run(input logic [15:0] exp_cnt);
        int k;
        sb.push_back({TAG, exp_cnt});
        out_ready   = 1'b1;
        encode_done = 1'b1;
        step();
        encode_done = 1'b0;
        k = 0;
        while (!pack_done && k < 200) begin
            step();
            k++;
        end
        check("pack_done", 32'(pack_done), 32'd1);
        check("word_cnt", 32'(word_cnt), 32'(exp_cnt));
        check("done_out_valid", 32'(out_valid), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    typedef struct {
        int          n;
        logic [3:0]  rdy;
        logic [31:0] base;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{n: 2,  rdy: 4'b1111, base: 32'h1111_1111, exp_cnt: 16'd2};
        vecs[1] = '{n: 8,  rdy: 4'b0101, base: 32'h0100_0001, exp_cnt: 16'd8};
        vecs[2] = '{n: 16, rdy: 4'b0000, base: 32'hA5A5_0000, exp_cnt: 16'd16};
        vecs[3] = '{n: 0,  rdy: 4'b1111, base: 32'h0,         exp_cnt: 16'd0};
        vecs[4] = '{n: 5,  rdy: 4'b0110, base: 32'h0000_0003, exp_cnt: 16'd5};

        rstN           = 1'b0;
        encode_start   = 1'b0;
        encode_done    = 1'b0;
        vlc_glue_data  = '0;
        vlc_glue_valid = 1'b0;
        out_ready      = 1'b0;
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_word_cnt", 32'(word_cnt), 32'd0);
        check("rst_pack_done", 32'(pack_done), 32'd0);
        rstN = 1'b1;
        step();

        // Table-driven runs: no overflow possible with at most 16 words from empty
        for (int v = 0; v < 5; v++) begin
            start_run();
            check("start_clears_done", 32'(pack_done), 32'd0);
            for (int i = 0; i < vecs[v].n; i++) begin
                logic [31:0] d;
                d = vecs[v].base * 32'(i + 1);
                sb.push_back(d);
                write_word(d, vecs[v].rdy[i % 4]);
            end
            finish_run(vecs[v].exp_cnt);
            check("vec_overflow", 32'(overflow), 32'd0);
        end

        // Overflow: 17 writes into a stalled 16-deep FIFO
        start_run();
        for (int i = 0; i < 17; i++) begin
            if (i < 16) sb.push_back(32'(i));
            write_word(32'(i), 1'b0);
        end
        check("ovf_level", 32'(fifo_level), 32'd16);
        check("ovf_flag", 32'(overflow), 32'd1);
        finish_run(16'd16);

        // Full FIFO: write and pop in the same cycle, write is dropped
        start_run();
        for (int i = 0; i < 16; i++) begin
            sb.push_back(32'h4000_0000 + 32'(i));
            write_word(32'h4000_0000 + 32'(i), 1'b0);
        end
        check("full_level", 32'(fifo_level), 32'd16);
        check("full_no_ovf", 32'(overflow), 32'd0);
        write_word(32'hDEAD_BEEF, 1'b1);
        check("collide_ovf", 32'(overflow), 32'd1);
        check("collide_level", 32'(fifo_level), 32'd15);
        finish_run(16'd16);

        // Early encode_done with 3 words queued, then a held trailer
        start_run();
        for (int i = 0; i < 3; i++) begin
            sb.push_back(32'h5000_0000 + 32'(i));
            write_word(32'h5000_0000 + 32'(i), 1'b0);
        end
        encode_done = 1'b1;
        step();
        encode_done = 1'b0;
        step();
        step();
        check("early_head_valid", 32'(out_valid), 32'd1);
        check("early_head_data", out_data, 32'h5000_0000);
        sb.push_back({TAG, 16'd3});
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("trl_hold_valid", 32'(out_valid), 32'd1);
            check("trl_hold_data", out_data, {TAG, 16'd3});
            check("trl_no_done", 32'(pack_done), 32'd0);
        end
        out_ready = 1'b1;
        step();
        step();
        check("trl_pack_done", 32'(pack_done), 32'd1);
        check("trl_sb_drained", 32'(sb.size()), 32'd0);

        // Reset mid-run with 5 words queued
        start_run();
        for (int i = 0; i < 5; i++) write_word(32'h6000_0000 + 32'(i), 1'b0);
        check("pre_rst_level", 32'(fifo_level), 32'd5);
        rstN = 1'b0;
        #2;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data", out_data, 32'd0);
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        check("mid_rst_word_cnt", 32'(word_cnt), 32'd0);
        check("mid_rst_pack_done", 32'(pack_done), 32'd0);
        step();
        rstN = 1'b1;
        step();
        start_run();
        check("post_rst_level", 32'(fifo_level), 32'd0);
        check("post_rst_word_cnt", 32'(word_cnt), 32'd0);
        check("post_rst_valid", 32'(out_valid), 32'd0);
        sb.push_back(32'h7777_0001);
        write_word(32'h7777_0001, 1'b1);
        finish_run(16'd1);

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
